// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main control unit:
// opcode constants, state encoding, datapath select codes and the
// packed control-word layout produced by the output decoder.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIWB = 4'd10
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] op_alu;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational Moore output decode for the multicycle MIPS control FSM.
// Ports: state (current FSM state), mem_ready (memory handshake) ->
//        ctrl (packed control word; every field defaults to 0).
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_4;
        ctrl.op_alu    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // PC+4 and IR capture only commit once the fetch has returned data
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMMSH;
        ctrl.op_alu    = ALU_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.op_alu    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.op_alu    = ALU_RTYPE;
      end
      S_RWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.op_alu        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      S_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath.
// Inputs: clk, rst_n (sync active-low), opcode (IR[31:26]), mem_ready.
// Outputs: datapath enables/selects (PCWrite..PCSource), OpALU code for
//          the ALU-control decoder, state_o (debug), instr_done and
//          illegal_op one-cycle pulses.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned OPW = 6,
  parameter int unsigned STW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  output logic           PCWrite,
  output logic           PCWriteCond,
  output logic           IorD,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic           MemtoReg,
  output logic           RegDst,
  output logic           RegWrite,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     OpALU,
  output logic [1:0]     PCSource,
  output logic [STW-1:0] state_o,
  output logic           instr_done,
  output logic           illegal_op
);

  state_t     state;
  state_t     state_next;
  ctrl_t      ctrl;
  logic [5:0] op;

  assign op = opcode[5:0];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW, OP_ADDI: state_next = S_MEMADR;
          OP_R:                  state_next = S_EXEC;
          OP_BEQ:                state_next = S_BRANCH;
          OP_J:                  state_next = S_JUMP;
          default:               state_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        case (op)
          OP_LW:   state_next = S_MEMRD;
          OP_SW:   state_next = S_MEMWR;
          OP_ADDI: state_next = S_ADDIWB;
          default: state_next = S_FETCH;
        endcase
      end
      S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_next = S_FETCH;
      S_EXEC:   state_next = S_RWB;
      default:  state_next = S_FETCH;
    endcase
  end

  mips_ctrl_outdec u_outdec (
    .state     (state),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign OpALU       = ctrl.op_alu;
  assign PCSource    = ctrl.pc_source;
  assign instr_done  = ctrl.instr_done;
  // Needs the opcode, so it lives beside the next-state decode
  assign illegal_op  = (state == S_DECODE) && !op_supported(op);
  assign state_o     = STW'(state);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, OpALU, PCSource;
  logic [3:0] state_o;
  logic       instr_done, illegal_op;

  int checks = 0;
  int errors = 0;

  mips_multicycle_ctrl #(.OPW(6), .STW(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .OpALU(OpALU),
    .PCSource(PCSource), .state_o(state_o), .instr_done(instr_done),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // Bit layout of the observed control vector:
  // 17 PCWrite 16 PCWriteCond 15 IorD 14 MemRead 13 MemWrite 12 IRWrite
  // 11 MemtoReg 10 RegDst 9 RegWrite 8 ALUSrcA 7:6 ALUSrcB 5:4 OpALU
  // 3:2 PCSource 1 instr_done 0 illegal_op
  logic [17:0] dut_vec;
  assign dut_vec = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                    MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, OpALU,
                    PCSource, instr_done, illegal_op};

  function automatic logic [17:0] exp_vec(input int st, input logic mr,
                                          input logic [5:0] op);
    logic [17:0] v;
    logic legal;
    v = '0;
    legal = (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
            (op == 6'b000100) || (op == 6'b000010) || (op == 6'b001000);
    case (st)
      0:  begin v[14] = 1; v[7:6] = 2'b01; v[17] = mr; v[12] = mr; end
      1:  begin v[7:6] = 2'b11; v[0] = !legal; end
      2:  begin v[8] = 1; v[7:6] = 2'b10; end
      3:  begin v[14] = 1; v[15] = 1; end
      4:  begin v[9] = 1; v[11] = 1; v[1] = 1; end
      5:  begin v[13] = 1; v[15] = 1; v[1] = mr; end
      6:  begin v[8] = 1; v[5:4] = 2'b10; end
      7:  begin v[9] = 1; v[10] = 1; v[1] = 1; end
      8:  begin v[8] = 1; v[5:4] = 2'b01; v[16] = 1; v[3:2] = 2'b01; v[1] = 1; end
      9:  begin v[17] = 1; v[3:2] = 2'b10; v[1] = 1; end
      10: begin v[9] = 1; v[1] = 1; end
      default: v = '0;
    endcase
    return v;
  endfunction

  // Model: after FETCH and DECODE, each instruction follows a fixed route
  // of states; routes containing memory states wait there for mem_ready.
  int m_state = 0;
  int route[$];
  bit model_valid = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_state = 0;
      route.delete();
      model_valid = 1;
    end else if (model_valid) begin
      if ((m_state == 0 || m_state == 3 || m_state == 5) && !mem_ready) begin
        // waiting on memory
      end else if (m_state == 0) begin
        m_state = 1;
      end else if (m_state == 1) begin
        route.delete();
        case (opcode)
          6'b100011: begin route.push_back(2); route.push_back(3); route.push_back(4); end
          6'b101011: begin route.push_back(2); route.push_back(5); end
          6'b001000: begin route.push_back(2); route.push_back(10); end
          6'b000000: begin route.push_back(6); route.push_back(7); end
          6'b000100: route.push_back(8);
          6'b000010: route.push_back(9);
          default: ;
        endcase
        m_state = (route.size() > 0) ? route.pop_front() : 0;
      end else begin
        m_state = (route.size() > 0) ? route.pop_front() : 0;
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      checks++;
      if (state_o !== 4'(m_state) || dut_vec !== exp_vec(m_state, mem_ready, opcode)) begin
        errors++;
        $display("FAIL model_cmp t=%0t state got %0d want %0d ctrl got %b want %b",
                 $time, state_o, m_state, dut_vec, exp_vec(m_state, mem_ready, opcode));
      end
      checks++;
      if ((MemRead && MemWrite) || (RegWrite && MemWrite)) begin
        errors++;
        $display("FAIL excl_pairs t=%0t got MemRead=%b MemWrite=%b RegWrite=%b want no overlap",
                 $time, MemRead, MemWrite, RegWrite);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got %0h want %0h", name, $time, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // path holds the expected state sequence as nibbles, first state in the
  // most significant used nibble; mem_ready is held at 1 throughout.
  task automatic run_path(input string name, input logic [31:0] path,
                          input int n, input logic done_last);
    logic [31:0] p;
    for (int i = 0; i < n; i++) begin
      p = path >> (4 * (n - 1 - i));
      chk({name, "_state"}, 32'(state_o), 32'(p[3:0]));
      chk({name, "_done"}, 32'(instr_done), (i == n - 1) ? 32'(done_last) : 32'd0);
      step();
    end
    chk({name, "_back_to_fetch"}, 32'(state_o), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t got timeout want completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    mem_ready = 1'b0;
    opcode = 6'b000000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'(state_o), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("fetch_memread", 32'(MemRead), 32'd1);
    chk("fetch_irwrite_wait", 32'(IRWrite), 32'd0);
    step();
    chk("fetch_hold", 32'(state_o), 32'd0);
    mem_ready = 1'b1;
    #1;
    chk("fetch_irwrite_ready", 32'(IRWrite), 32'd1);
    chk("fetch_pcwrite_ready", 32'(PCWrite), 32'd1);

    opcode = 6'b100011;
    run_path("lw", 32'h01234, 5, 1'b1);

    // sw with three stall cycles in MEMWR
    opcode = 6'b101011;
    chk("sw_s0", 32'(state_o), 32'd0); step();
    chk("sw_s1", 32'(state_o), 32'd1); step();
    chk("sw_s2", 32'(state_o), 32'd2); step();
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("sw_stall_state", 32'(state_o), 32'd5);
      chk("sw_stall_memwrite", 32'(MemWrite), 32'd1);
      chk("sw_stall_done", 32'(instr_done), 32'd0);
      step();
    end
    mem_ready = 1'b1;
    #1;
    chk("sw_ready_state", 32'(state_o), 32'd5);
    chk("sw_ready_memwrite", 32'(MemWrite), 32'd1);
    chk("sw_ready_done", 32'(instr_done), 32'd1);
    step();
    chk("sw_back_to_fetch", 32'(state_o), 32'd0);

    opcode = 6'b000000;
    chk("rtype_exec_peek_opalu_pre", 32'(OpALU), 32'd0);
    run_path("rtype", 32'h0167, 4, 1'b1);
    opcode = 6'b000100;
    run_path("beq", 32'h018, 3, 1'b1);
    opcode = 6'b000010;
    run_path("j", 32'h019, 3, 1'b1);
    opcode = 6'b001000;
    run_path("addi", 32'h012A, 4, 1'b1);

    // illegal opcode
    opcode = 6'b111111;
    step();
    chk("illegal_state", 32'(state_o), 32'd1);
    chk("illegal_pulse", 32'(illegal_op), 32'd1);
    chk("illegal_regwrite", 32'(RegWrite), 32'd0);
    step();
    chk("illegal_to_fetch", 32'(state_o), 32'd0);
    chk("illegal_pulse_gone", 32'(illegal_op), 32'd0);

    // reset while stalled in MEMRD
    opcode = 6'b100011;
    step(); step(); step();
    chk("stall_memrd", 32'(state_o), 32'd3);
    mem_ready = 1'b0;
    step(); step();
    chk("stall_memrd_hold", 32'(state_o), 32'd3);
    rst_n = 1'b0;
    step();
    chk("stall_reset_state", 32'(state_o), 32'd0);
    chk("stall_reset_regwrite", 32'(RegWrite), 32'd0);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives every datapath enable and mux select, and supplies the 2-bit OpALU code consumed by the ALU-control decoder.
- Stalls on memory-access states until the memory reports ready.

Parameters:
- OPW, 6, opcode field width.
- STW, 4, state register width.

Ports:
- clk  in  1  system clock; all state updates occur on its rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- opcode  in  OPW  instruction bits [31:26], taken from the instruction register.
- mem_ready  in  1  memory completed the current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load qualified by ALU zero (beq).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  register write data select: 0 = ALUOut, 1 = MDR.
- RegDst  out  1  destination register select: 0 = rt, 1 = rd.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = register A.
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- OpALU  out  2  00 = add, 01 = subtract (beq), 10 = R-type (use funct).
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- state_o  out  STW  current state, for debug.
- instr_done  out  1  one-cycle pulse in the final state of each instruction.
- illegal_op  out  1  one-cycle pulse in DECODE when the opcode is unsupported.

Behaviour:
- Outputs are Moore: decoded only from the current state, plus mem_ready where noted below. Any output not listed for a state is 0.
- Reset: when rst_n=0 at a rising edge, state becomes FETCH. Reset wins over every other transition, including mid-instruction and mid-stall.
- Opcodes: R = 000000, lw = 100011, sw = 101011, beq = 000100, j = 000010, addi = 001000.
- FETCH (0):
  - Outputs: MemRead=1, ALUSrcB=01, OpALU=00, PCSource=00.
  - IRWrite=mem_ready and PCWrite=mem_ready.
  - Transition: go to DECODE when mem_ready=1; otherwise hold.
- DECODE (1):
  - Outputs: ALUSrcB=11, OpALU=00 (branch target precompute).
  - Transitions: lw/sw/addi go to MEMADR, R goes to EXEC, beq goes to BRANCH, j goes to JUMP.
  - Any other opcode: illegal_op=1 and go to FETCH.
- MEMADR (2):
  - Outputs: ALUSrcA=1, ALUSrcB=10, OpALU=00.
  - Transitions: lw goes to MEMRD, sw goes to MEMWR, addi goes to ADDIWB.
- MEMRD (3):
  - Outputs: MemRead=1, IorD=1.
  - Transition: go to MEMWB when mem_ready=1; otherwise hold.
- MEMWB (4):
  - Outputs: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1.
  - Transition: go to FETCH.
- MEMWR (5):
  - Outputs: MemWrite=1 and IorD=1, held for every cycle spent in this state.
  - instr_done=mem_ready.
  - Transition: go to FETCH when mem_ready=1; otherwise hold.
- EXEC (6):
  - Outputs: ALUSrcA=1, ALUSrcB=00, OpALU=10.
  - Transition: go to RWB.
- RWB (7):
  - Outputs: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1.
  - Transition: go to FETCH.
- BRANCH (8):
  - Outputs: ALUSrcA=1, ALUSrcB=00, OpALU=01, PCWriteCond=1, PCSource=01, instr_done=1.
  - Transition: go to FETCH.
- JUMP (9):
  - Outputs: PCWrite=1, PCSource=10, instr_done=1.
  - Transition: go to FETCH.
- ADDIWB (10):
  - Outputs: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1.
  - Transition: go to FETCH.
- Any unused encoding (11 to 15): all outputs 0; go to FETCH on the next edge.
- Opcode handling: opcode is sampled only in DECODE and MEMADR. The instruction register holds it stable because IRWrite=0 outside FETCH.
- Never-asserted pairs: MemRead and MemWrite are never both 1. RegWrite and MemWrite are never both 1.
- Instruction latency with mem_ready tied to 1: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants;
  - the state encoding, as a typedef enum of width STW;
  - the OpALU, ALUSrcB and PCSource code constants.
- One natural sub-module, mips_ctrl_outdec: a purely combinational decode from state, plus mem_ready, to the output vector.
- The top-level module holds the state register and the next-state logic.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then 1 -> state_o=0, MemRead=1, IRWrite=1 only while mem_ready=1.
- lw with mem_ready=1: opcode=100011 -> states 0,1,2,3,4,0; instr_done high only in state 4; RegWrite=1, MemtoReg=1 in state 4.
- sw with mem_ready=0 for 3 cycles in MEMWR: opcode=101011 -> state stays 5 with MemWrite=1 for 4 cycles; instr_done=1 only in the cycle mem_ready=1; then FETCH.
- R-type then beq back-to-back: opcode=000000 -> EXEC with OpALU=10, then RWB with RegDst=1; next opcode=000100 -> BRANCH with OpALU=01, PCWriteCond=1, PCSource=01.
- j and an illegal opcode: opcode=000010 -> JUMP with PCWrite=1, PCSource=10; opcode=111111 -> illegal_op pulses in DECODE, then FETCH, with no RegWrite or MemWrite asserted.
- Reset mid-stall: hold in MEMRD with mem_ready=0, drive rst_n=0 for one edge -> state_o=0 on the next cycle; no RegWrite pulse ever occurs.
